driver_rx: RTL and testbench
============================

# driver_rx

Deserializer for the LED-board chain protocol (serial clock, data, latch) that our `driver` block emits. It oversamples the three lines on the system clock and recovers each `c_bpc`-bit channel word, MSB first. It writes every word into a frame buffer at the original buffer address, undoing the per-16 index reversal applied on transmit. It flags frame completion or error on each latch. It is used in the loopback self-test and in the board-side emulator.

## Interface
Parameters:
- `c_ledboards`, 30, number of boards in the chain.
- `c_bpc`, 12, bits per channel word.
- `c_channels`, `c_ledboards*32`, words per frame.
- `c_addr_w`, `$clog2(c_channels)`, buffer address width.
- `c_idle_cycles`, 64, `i_clk` cycles without an `i_sclk` rise mid-word before the partial word is aborted.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk`, in, 1: system clock.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_sclk`, in, 1: serial clock, asynchronous to `i_clk`.
- `i_sdi`, in, 1: serial data, sampled on the `i_sclk` rise.
- `i_lat`, in, 1: latch; its rise ends the frame.
- `o_wr_en`, out, 1: one-cycle write strobe.
- `o_wr_addr`, out, `c_addr_w`: buffer address.
- `o_wr_data`, out, `c_bpc`: recovered word.
- `o_frame_done`, out, 1: one-cycle pulse on a latch after exactly `c_channels` complete words.
- `o_frame_err`, out, 1: one-cycle pulse on a latch for any other condition.
- `o_busy`, out, 1: high while in `s_recv`.

## Operation
Input conditioning:
- `i_sclk`, `i_sdi` and `i_lat` each pass through a 2-FF synchronizer, then a 1-FF history register.
- A rise is detected as `sync & ~hist`.

State machine, 2-bit: `s_idle`, `s_recv`, `s_done`.
- **`s_idle`:**
  - The word and bit counters are zero.
  - An `sclk` rise shifts in the first bit and moves to `s_recv`.
  - A `lat` rise here pulses `o_frame_err`: an empty frame.
- **`s_recv`:**
  - Each `sclk` rise shifts `sdi` into the LSB of the shift register. Earlier bits move toward the MSB.
  - Each rise increments `bitcnt` (width `$clog2(c_bpc+1)`).
  - When `bitcnt` reaches `c_bpc`:
    - If `wordcnt < c_channels`: write the word to address `map(wordcnt)`, then increment `wordcnt`.
    - Otherwise: discard the word and set the sticky `ovf` flag.
    - In both cases clear `bitcnt`.
  - A `lat` rise moves to `s_done`.
- **`s_done`, one cycle:**
  - Pulse `o_frame_done` if `wordcnt == c_channels`, `bitcnt == 0`, `ovf == 0` and `abort == 0`. Otherwise pulse `o_frame_err`.
  - Clear all counters and flags, then return to `s_idle`.

Address map: `map(k) = {k[c_addr_w-1:4], 4'd15 - k[3:0]}`. This is the inverse of the transmit order.
- Example: `k=0` → 15, `k=15` → 0, `k=16` → 31, `k=959` → 944.
- `c_channels` is always a multiple of 32, so no out-of-range addresses occur.

Idle timeout:
- The `idle` counter, saturating at `c_idle_cycles`, clears on every `sclk` rise and counts while `bitcnt != 0`.
- On reaching `c_idle_cycles`: clear `bitcnt`, drop the partial word and set sticky `abort`.
- Gaps between words with `bitcnt == 0` are unlimited.

Simultaneous events:
- If an `sclk` rise and a `lat` rise are detected in the same cycle, the bit is processed first, including any write, and the latch is evaluated on the updated counters in `s_done`.
- A timeout and an `sclk` rise in the same cycle: the rise wins and the counter clears.

Reset, asserted at any time, including mid-frame:
- All outputs go to 0.
- The FSM goes to `s_idle`.
- Counters, flags, synchronizers and history registers are cleared.
- No write or pulse is emitted for the interrupted frame.

## Timing
Serial line limits:
- `i_sclk` high and low phases must each be at least 2 `i_clk` periods.
- `i_sdi` must be stable from 1 `i_clk` before to 1 `i_clk` after the `i_sclk` rise.
- `i_lat` high for at least 2 `i_clk`, rising at least 2 `i_clk` after the last `i_sclk` fall.

Latencies:
- `o_wr_en`, `o_wr_addr` and `o_wr_data` are registered and valid together for exactly 1 cycle, 3 `i_clk` edges after the 12th `i_sclk` rise at the pin.
- `o_frame_done` / `o_frame_err` pulse 4 `i_clk` edges after the `i_lat` rise at the pin: 3 edges to `s_done`, plus 1 registered pulse.
- The next frame may start `sclk` rises on the cycle after `s_done`.

`o_busy` is registered from the state.

Reset values: `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_frame_done`=0, `o_frame_err`=0, `o_busy`=0.

## Test plan
- **Full frame:** 960 words, value = `k[11:0]`, sclk at `i_clk/4`, then latch. Expect 960 writes, the word at stream position k written to address `map(k)`, and a single `o_frame_done`.
- **Bit order and map:** first word `0xA5C`, rest zero. Expect the first write `addr=15`, `data=0xA5C`. Stream position 16 is written to `addr=31`.
- **Short frame:** 959 words, then latch. Expect 959 writes, `o_frame_err`=1, `o_frame_done`=0. The next full frame gives `o_frame_done`.
- **Overflow and partial word:** 961 words then latch; expect 960 writes and `o_frame_err`. Separately, 960 words plus 5 bits then latch; expect `o_frame_err`.
- **Idle timeout:** word 10 stalls after 6 bits for 70 cycles, then the frame continues with 950 full words. Expect no write for the partial word, words after the stall mapped from position 10 onward, and `o_frame_err` at latch.
- **Reset mid-frame:** assert `i_rst_n`=0 after 500 words. Expect all outputs 0 immediately. After release, a full frame produces 960 writes and `o_frame_done`.

Source files
------------

// File: rtl/driver_rx.sv
// Deserializer for the LED-board chain protocol: oversamples sclk/sdi/lat on i_clk,
// rebuilds each channel word MSB first and writes it back to its original buffer address.
module driver_rx #(
    parameter int c_ledboards   = 30,
    parameter int c_bpc         = 12,
    parameter int c_channels    = c_ledboards * 32,
    parameter int c_addr_w      = $clog2(c_channels),
    parameter int c_idle_cycles = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sclk,
    input  logic                i_sdi,
    input  logic                i_lat,
    output logic                o_wr_en,
    output logic [c_addr_w-1:0] o_wr_addr,
    output logic [c_bpc-1:0]    o_wr_data,
    output logic                o_frame_done,
    output logic                o_frame_err,
    output logic                o_busy
);

    localparam int c_bc_w = $clog2(c_bpc + 1);
    localparam int c_wc_w = $clog2(c_channels + 1);
    localparam int c_id_w = $clog2(c_idle_cycles + 1);

    localparam logic [c_bc_w-1:0] c_bpc_v     = c_bc_w'(c_bpc);
    localparam logic [c_wc_w-1:0] c_chan_v    = c_wc_w'(c_channels);
    localparam logic [c_id_w-1:0] c_idle_v    = c_id_w'(c_idle_cycles);
    localparam logic [c_id_w-1:0] c_idle_last = c_id_w'(c_idle_cycles - 1);

    localparam logic [1:0] s_idle = 2'd0;
    localparam logic [1:0] s_recv = 2'd1;
    localparam logic [1:0] s_done = 2'd2;

    // Transmit reverses the index inside every group of 16; undo it here.
    function automatic logic [c_addr_w-1:0] map_addr(input logic [c_addr_w-1:0] k);
        map_addr = {k[c_addr_w-1:4], 4'd15 - k[3:0]};
    endfunction

    // Synchronizer bit order is {lat, sdi, sclk}; history only for the edge-detected lines.
    logic [2:0]          meta_q, meta_d, sync_q, sync_d;
    logic [1:0]          hist_q, hist_d;
    logic [1:0]          state_q, state_d;
    logic [c_bpc-2:0]    shreg_q, shreg_d;
    logic [c_bc_w-1:0]   bitcnt_q, bitcnt_d;
    logic [c_wc_w-1:0]   wordcnt_q, wordcnt_d;
    logic [c_id_w-1:0]   idle_q, idle_d;
    logic                ovf_q, ovf_d, abort_q, abort_d;
    logic                wr_en_q, wr_en_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
    logic [c_addr_w-1:0] wr_addr_q, wr_addr_d;
    logic [c_bpc-1:0]    wr_data_q, wr_data_d;
    logic                sclk_rise, lat_rise;
    logic [c_bpc-1:0]    shifted;
    logic [c_bc_w-1:0]   bit_next;

    // Next-state logic: conditioning, bit assembly, write strobe, idle timeout and frame verdict.
    always_comb begin
        meta_d    = {i_lat, i_sdi, i_sclk};
        sync_d    = meta_q;
        hist_d    = {sync_q[2], sync_q[0]};
        sclk_rise = sync_q[0] & ~hist_q[0];
        lat_rise  = sync_q[2] & ~hist_q[1];
        shifted   = {shreg_q, sync_q[1]};
        bit_next  = bitcnt_q + c_bc_w'(1);

        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        wordcnt_d = wordcnt_q;
        idle_d    = idle_q;
        ovf_d     = ovf_q;
        abort_d   = abort_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            s_idle, s_recv: begin
                if (sclk_rise) begin
                    shreg_d = shifted[c_bpc-2:0];
                    idle_d  = '0;
                    if (bit_next == c_bpc_v) begin
                        bitcnt_d = '0;
                        if (wordcnt_q < c_chan_v) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = map_addr(wordcnt_q[c_addr_w-1:0]);
                            wr_data_d = shifted;
                            wordcnt_d = wordcnt_q + c_wc_w'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        bitcnt_d = bit_next;
                    end
                end else if (bitcnt_q != '0) begin
                    if (idle_q == c_idle_last) begin
                        idle_d   = c_idle_v;
                        bitcnt_d = '0;
                        abort_d  = 1'b1;
                    end else if (idle_q != c_idle_v) begin
                        idle_d = idle_q + c_id_w'(1);
                    end else begin
                        idle_d = idle_q;
                    end
                end else begin
                    idle_d = idle_q;
                end

                // A bit arriving with the latch is folded in before the verdict in s_done.
                if (lat_rise) begin
                    state_d = s_done;
                end else if (sclk_rise) begin
                    state_d = s_recv;
                end else begin
                    state_d = state_q;
                end
            end
            s_done: begin
                if ((wordcnt_q == c_chan_v) && (bitcnt_q == '0) && !ovf_q && !abort_q) begin
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                bitcnt_d  = '0;
                wordcnt_d = '0;
                idle_d    = '0;
                ovf_d     = 1'b0;
                abort_d   = 1'b0;
                state_d   = s_idle;
            end
            default: begin
                state_d = s_idle;
            end
        endcase

        busy_d = (state_d == s_recv);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q    <= '0;
            sync_q    <= '0;
            hist_q    <= '0;
            state_q   <= s_idle;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            wordcnt_q <= '0;
            idle_q    <= '0;
            ovf_q     <= 1'b0;
            abort_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            wordcnt_q <= wordcnt_d;
            idle_q    <= idle_d;
            ovf_q     <= ovf_d;
            abort_q   <= abort_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_driver_rx.sv
// Bench for driver_rx: a table of frame scenarios plus hand-written latency, empty-latch
// and mid-frame reset sequences. Uses a two-board chain (64 words) to keep frames short.
module tb_driver_rx;

    localparam int LB  = 2;
    localparam int NCH = LB * 32;
    localparam int BPC = 12;
    localparam int AW  = $clog2(NCH);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sclk = 1'b0;
    logic           sdi = 1'b0;
    logic           lat = 1'b0;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [BPC-1:0] wr_data;
    logic           frame_done;
    logic           frame_err;
    logic           busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    driver_rx #(.c_ledboards(LB)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sclk      (sclk),
        .i_sdi       (sdi),
        .i_lat       (lat),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_frame_done(frame_done),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    // Write/pulse monitor, sampled on the falling edge.
    logic [AW-1:0]  mon_addr[$];
    logic [BPC-1:0] mon_data[$];
    int n_done = 0;
    int n_err  = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(wr_addr);
            mon_data.push_back(wr_data);
        end
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int nwords;
        int extra_bits;
        int stall_at;
        int exp_writes;
        int exp_done;
        int exp_err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int map_k(input int k);
        return (k / 16) * 16 + (15 - (k % 16));
    endfunction

    function automatic logic [11:0] wval(input int k, input int seed);
        return 12'((k * 7 + seed * 331 + 5) % 4096);
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk) sdi = b;
        @(negedge clk) sclk = 1'b1;
        @(negedge clk);
        @(negedge clk) sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[11-i]);
    endtask

    task automatic do_latch();
        repeat (2) @(negedge clk);
        lat = 1'b1;
        repeat (2) @(negedge clk);
        lat = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v, input int seed);
        logic [AW-1:0]  ea[$];
        logic [BPC-1:0] ed[$];
        int b_wr;
        int b_d;
        int b_e;
        int got;
        b_wr = mon_addr.size();
        b_d  = n_done;
        b_e  = n_err;
        for (int k = 0; k < v.nwords; k++) begin
            if (k == v.stall_at) begin
                send_bits(12'hFFF ^ wval(k, seed), 6);
                repeat (70) @(negedge clk);
            end
            send_bits(wval(k, seed), 12);
            if (k < NCH) begin
                ea.push_back(AW'(map_k(k)));
                ed.push_back(wval(k, seed));
            end
        end
        if (v.extra_bits > 0) send_bits(12'hABC, v.extra_bits);
        do_latch();
        got = mon_addr.size() - b_wr;
        check($sformatf("v%0d writes", idx), got, v.exp_writes);
        for (int i = 0; i < ea.size() && i < got; i++) begin
            check($sformatf("v%0d addr[%0d]", idx, i), mon_addr[b_wr+i], ea[i]);
            check($sformatf("v%0d data[%0d]", idx, i), mon_data[b_wr+i], ed[i]);
        end
        check($sformatf("v%0d done", idx), n_done - b_d, v.exp_done);
        check($sformatf("v%0d err", idx), n_err - b_e, v.exp_err);
        check($sformatf("v%0d busy_after", idx), busy, 0);
    endtask

    initial begin
        vec_t vecs[6];
        int b_wr;
        int b_d;
        int b_e;
        logic [11:0] first;

        // full, short, full again, overflow, trailing partial word, idle-timeout stall
        vecs[0] = '{NCH,     0, -1, NCH,     1, 0};
        vecs[1] = '{NCH - 1, 0, -1, NCH - 1, 0, 1};
        vecs[2] = '{NCH,     0, -1, NCH,     1, 0};
        vecs[3] = '{NCH + 1, 0, -1, NCH,     0, 1};
        vecs[4] = '{NCH,     5, -1, NCH,     0, 1};
        vecs[5] = '{NCH,     0, 10, NCH,     0, 1};

        repeat (3) @(negedge clk);
        #1;
        check("rst wr_en", wr_en, 0);
        check("rst wr_addr", wr_addr, 0);
        check("rst wr_data", wr_data, 0);
        check("rst done", frame_done, 0);
        check("rst err", frame_err, 0);
        check("rst busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Latch with no data is an empty frame.
        b_d = n_done;
        b_e = n_err;
        do_latch();
        check("empty done", n_done - b_d, 0);
        check("empty err", n_err - b_e, 1);

        // Bit order, map and exact write/latch latencies.
        first = 12'hA5C;
        b_wr = mon_addr.size();
        b_d  = n_done;
        send_bits(first, 11);
        check("busy recv", busy, 1);
        @(negedge clk) sdi = first[0];
        @(negedge clk) sclk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("wr_en edge2", wr_en, 0);
        @(posedge clk);
        #1;
        check("wr_en edge3", wr_en, 1);
        check("first addr", wr_addr, 15);
        check("first data", wr_data, 12'hA5C);
        @(posedge clk);
        #1;
        check("wr_en edge4", wr_en, 0);
        @(negedge clk) sclk = 1'b0;
        for (int k = 1; k < NCH; k++) send_bits(wval(k, 99), 12);
        repeat (2) @(negedge clk);
        lat = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("done edge3", frame_done, 0);
        @(posedge clk);
        #1;
        check("done edge4", frame_done, 1);
        @(negedge clk) lat = 1'b0;
        repeat (4) @(negedge clk);
        check("bo writes", mon_addr.size() - b_wr, NCH);
        if (mon_addr.size() - b_wr > 16) begin
            check("pos16 addr", mon_addr[b_wr+16], 31);
            check("pos16 data", mon_data[b_wr+16], wval(16, 99));
        end else begin
            check("pos16 present", mon_addr.size() - b_wr, 17);
        end
        check("bo done", n_done - b_d, 1);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i], i + 1);

        // Reset in the middle of a frame, then a clean frame.
        for (int k = 0; k < NCH / 2; k++) send_bits(wval(k, 42), 12);
        check("busy pre-rst", busy, 1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid-rst wr_en", wr_en, 0);
        check("mid-rst wr_addr", wr_addr, 0);
        check("mid-rst wr_data", wr_data, 0);
        check("mid-rst done", frame_done, 0);
        check("mid-rst err", frame_err, 0);
        check("mid-rst busy", busy, 0);
        b_wr = mon_addr.size();
        b_d  = n_done;
        b_e  = n_err;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post-rst writes", mon_addr.size() - b_wr, 0);
        check("post-rst pulses", (n_done - b_d) + (n_err - b_e), 0);
        run_vec(6, vecs[0], 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
